// File: rtl/scratchpad_pkg.sv
// Shared types and widths for the 128-bit scratchpad responder and its clear engine.
// Nothing in this file depends on the SCRATCHPAD_BYPASS_EN option.
package scratchpad_pkg;

    localparam int DATA_W = 128;
    localparam int ADDR_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } clear_state_t;

    // Compare at full width so addresses above DEPTH never alias onto real words.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return 32'(addr) < depth;
    endfunction

endpackage

// File: rtl/scratchpad_clear_fsm.sv
// Zero-fill sweep engine: walks word 0..DEPTH-1 writing zero, then pulses done.
// Its write request has priority over the external write port in the top level.
//
//   state | meaning
//   IDLE  | waiting for clear request, no writes issued
//   CLEAR | writing zero to word r_cnt this cycle, busy asserted
//   DONE  | sweep finished, done asserted for exactly one cycle
module scratchpad_clear_fsm
    import scratchpad_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             i_clear_req,
    output logic             o_clear_busy,
    output logic             o_clear_done,
    output logic             o_clr_we,
    output logic [IDX_W-1:0] o_clr_addr
);

    clear_state_t     r_state;
    clear_state_t     w_next_state;
    logic [IDX_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == IDX_W'(DEPTH - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == CLEAR) begin
                r_cnt <= w_last ? '0 : r_cnt + IDX_W'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end

    // Requests arriving in CLEAR or DONE are dropped, not queued.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (i_clear_req) w_next_state = CLEAR;
            CLEAR:   if (w_last)      w_next_state = DONE;
            DONE:                     w_next_state = IDLE;
            default:                  w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_clear_busy = 1'b0;
        o_clear_done = 1'b0;
        o_clr_we     = 1'b0;
        o_clr_addr   = r_cnt;
        case (r_state)
            CLEAR: begin
                o_clear_busy = 1'b1;
                o_clr_we     = 1'b1;
            end
            DONE:    o_clear_done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/scratchpad_responder.sv
// Two-read/one-write 128-bit scratchpad with a built-in zero-fill clear engine.
// Build option SCRATCHPAD_BYPASS_EN: write-first read-during-write (default is read-first).
module scratchpad_responder
    import scratchpad_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ReadAddress1,
    output logic [DATA_W-1:0] ReadBus1,
    input  logic [ADDR_W-1:0] ReadAddress2,
    output logic [DATA_W-1:0] ReadBus2,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [DATA_W-1:0] WriteBus,
    input  logic              WriteEnable,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              oob_err
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic              r_oob;

    logic              w_rd1_ok;
    logic              w_rd2_ok;
    logic              w_wa_ok;
    logic              w_ext_we;
    logic              w_clr_we;
    logic              w_clr_busy;
    logic              w_clr_done;
    logic [IDX_W-1:0]  w_clr_addr;
    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rd1_next;
    logic [DATA_W-1:0] w_rd2_next;
    logic              w_oob;

    scratchpad_clear_fsm #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_clear_fsm (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clear_req  (clear_req),
        .o_clear_busy (w_clr_busy),
        .o_clear_done (w_clr_done),
        .o_clr_we     (w_clr_we),
        .o_clr_addr   (w_clr_addr)
    );

    assign w_rd1_ok = addr_in_range(ReadAddress1, DEPTH);
    assign w_rd2_ok = addr_in_range(ReadAddress2, DEPTH);
    assign w_wa_ok  = addr_in_range(WriteAddress, DEPTH);

    // External writes are silently dropped while the sweep owns the array.
    assign w_ext_we   = WriteEnable & w_wa_ok & ~w_clr_busy;
    assign w_mem_we   = w_clr_we | w_ext_we;
    assign w_mem_addr = w_clr_we ? w_clr_addr : WriteAddress[IDX_W-1:0];
    assign w_mem_data = w_clr_we ? '0 : WriteBus;

    assign w_oob = ~w_rd1_ok | ~w_rd2_ok | (WriteEnable & ~w_wa_ok);

    always_comb begin
        w_rd1_next = '0;
        if (w_rd1_ok && !w_clr_busy) begin
            w_rd1_next = r_mem[ReadAddress1[IDX_W-1:0]];
`ifdef SCRATCHPAD_BYPASS_EN
            if (w_ext_we && (ReadAddress1 == WriteAddress)) begin
                w_rd1_next = WriteBus;
            end
`endif
        end
    end

    always_comb begin
        w_rd2_next = '0;
        if (w_rd2_ok && !w_clr_busy) begin
            w_rd2_next = r_mem[ReadAddress2[IDX_W-1:0]];
`ifdef SCRATCHPAD_BYPASS_EN
            if (w_ext_we && (ReadAddress2 == WriteAddress)) begin
                w_rd2_next = WriteBus;
            end
`endif
        end
    end

    // Storage is deliberately not reset; the clear engine is the way to zero it.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
            r_oob <= 1'b0;
        end else begin
            r_rd1 <= w_rd1_next;
            r_rd2 <= w_rd2_next;
            r_oob <= w_oob;
        end
    end

    assign ReadBus1   = r_rd1;
    assign ReadBus2   = r_rd2;
    assign oob_err    = r_oob;
    assign clear_busy = w_clr_busy;
    assign clear_done = w_clr_done;

endmodule

// File: tb/tb_scratchpad_responder.sv
// Directed bench for scratchpad_responder: vector table for the single-cycle port behaviour,
// hand-written sequences for the clear sweep and reset during a sweep.
module tb_scratchpad_responder;

    logic         clock = 1'b0;
    logic         reset_n;
    logic [15:0]  ReadAddress1, ReadAddress2, WriteAddress;
    logic [127:0] ReadBus1, ReadBus2, WriteBus;
    logic         WriteEnable, clear_req;
    logic         clear_busy, clear_done, oob_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] M0   = 128'h0BAD_0000_0000_0000_0000_0000_0000_0B0D;
    localparam logic [127:0] M44  = 128'h44;
    localparam logic [127:0] A5   = 128'h0A5;
    localparam logic [127:0] D0   = {4{32'h1111_1111}};
    localparam logic [127:0] D1   = {4{32'h2222_2222}};
    localparam logic [127:0] X255 = {4{32'hFF00_FF00}};
    localparam logic [127:0] JUNK = {4{32'hDEAD_BEEF}};
`ifdef SCRATCHPAD_BYPASS_EN
    localparam logic [127:0] BYP1 = D1;
    localparam logic [127:0] BYP2 = D0;
`else
    localparam logic [127:0] BYP1 = D0;
    localparam logic [127:0] BYP2 = A5;
`endif

    scratchpad_responder dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .ReadAddress1 (ReadAddress1),
        .ReadBus1     (ReadBus1),
        .ReadAddress2 (ReadAddress2),
        .ReadBus2     (ReadBus2),
        .WriteAddress (WriteAddress),
        .WriteBus     (WriteBus),
        .WriteEnable  (WriteEnable),
        .clear_req    (clear_req),
        .clear_busy   (clear_busy),
        .clear_done   (clear_done),
        .oob_err      (oob_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic         we;
        logic [15:0]  wa;
        logic [127:0] wd;
        logic [15:0]  ra1;
        logic [15:0]  ra2;
        logic         chk;
        logic [127:0] e1;
        logic [127:0] e2;
        logic         eoob;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_clear(input bit inject, output int n_busy);
        WriteEnable = 1'b0;
        clear_req   = 1'b1;
        step();
        clear_req = 1'b0;
        n_busy    = 0;
        for (int i = 0; i < 400 && clear_busy; i++) begin
            n_busy++;
            if (inject && i == 0)  check("read_before_sweep", ReadBus1, X255);
            if (inject && i == 20) check("read_during_sweep", ReadBus1, 128'd0);
            WriteEnable = 1'b0;
            clear_req   = 1'b0;
            if (inject && i == 50) begin
                WriteEnable  = 1'b1;
                WriteAddress = 16'd5;
                WriteBus     = JUNK;
            end
            if (inject && i == 100) clear_req = 1'b1;
            step();
        end
        WriteEnable = 1'b0;
        clear_req   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_busy;
        int unsigned rd_addrs [6];

        //         we    wa        wd    ra1       ra2       chk   e1      e2      eoob
        vecs[0]  = '{1'b1, 16'd0,    M0,   16'd0,    16'd0,    1'b0, 128'd0, 128'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'd44,   M44,  16'd0,    16'd0,    1'b1, M0,     M0,     1'b0};
        vecs[2]  = '{1'b1, 16'd3,    A5,   16'd44,   16'd0,    1'b1, M44,    M0,     1'b0};
        vecs[3]  = '{1'b1, 16'd7,    D0,   16'd3,    16'd3,    1'b1, A5,     A5,     1'b0};
        vecs[4]  = '{1'b1, 16'd7,    D1,   16'd7,    16'd3,    1'b1, BYP1,   A5,     1'b0};
        vecs[5]  = '{1'b0, 16'd7,    JUNK, 16'd7,    16'd7,    1'b1, D1,     D1,     1'b0};
        vecs[6]  = '{1'b1, 16'd300,  JUNK, 16'd3,    16'd256,  1'b1, A5,     128'd0, 1'b1};
        vecs[7]  = '{1'b0, 16'd0,    0,    16'd44,   16'd3,    1'b1, M44,    A5,     1'b0};
        vecs[8]  = '{1'b1, 16'd1000, JUNK, 16'hFFFF, 16'd256,  1'b1, 128'd0, 128'd0, 1'b1};
        vecs[9]  = '{1'b0, 16'd300,  JUNK, 16'd0,    16'd44,   1'b1, M0,     M44,    1'b0};
        vecs[10] = '{1'b1, 16'd255,  X255, 16'd7,    16'd0,    1'b1, D1,     M0,     1'b0};
        vecs[11] = '{1'b1, 16'd256,  JUNK, 16'd255,  16'd255,  1'b1, X255,   X255,   1'b1};
        vecs[12] = '{1'b0, 16'd0,    0,    16'd0,    16'd255,  1'b1, M0,     X255,   1'b0};
        vecs[13] = '{1'b1, 16'd3,    D0,   16'd7,    16'd3,    1'b1, D1,     BYP2,   1'b0};
        vecs[14] = '{1'b0, 16'd0,    0,    16'd3,    16'd3,    1'b1, D0,     D0,     1'b0};

        reset_n      = 1'b0;
        ReadAddress1 = '0;
        ReadAddress2 = '0;
        WriteAddress = '0;
        WriteBus     = '0;
        WriteEnable  = 1'b0;
        clear_req    = 1'b0;
        step();
        step();
        check("reset_rd1",  ReadBus1,   128'd0);
        check("reset_rd2",  ReadBus2,   128'd0);
        check("reset_busy", clear_busy, 128'd0);
        check("reset_done", clear_done, 128'd0);
        check("reset_oob",  oob_err,    128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < NVEC; i++) begin
            WriteEnable  = vecs[i].we;
            WriteAddress = vecs[i].wa;
            WriteBus     = vecs[i].wd;
            ReadAddress1 = vecs[i].ra1;
            ReadAddress2 = vecs[i].ra2;
            step();
            if (vecs[i].chk) begin
                check($sformatf("vec%0d_rd1", i), ReadBus1, vecs[i].e1);
                check($sformatf("vec%0d_rd2", i), ReadBus2, vecs[i].e2);
            end
            check($sformatf("vec%0d_oob", i), oob_err, 128'(vecs[i].eoob));
        end
        WriteEnable = 1'b0;

        // Full sweep with a dropped write and an ignored second request mid-sweep.
        ReadAddress1 = 16'd255;
        ReadAddress2 = 16'd0;
        run_clear(1'b1, n_busy);
        check("clear_busy_cycles", 128'(n_busy), 128'd256);
        check("clear_done_pulse",  clear_done, 128'd1);
        step();
        check("clear_done_low",    clear_done, 128'd0);
        check("clear_no_restart",  clear_busy, 128'd0);

        rd_addrs = '{0, 3, 5, 7, 44, 255};
        for (int k = 0; k < 6; k++) begin
            ReadAddress1 = 16'(rd_addrs[k]);
            ReadAddress2 = 16'(rd_addrs[k]);
            step();
            check($sformatf("cleared_rd1_%0d", rd_addrs[k]), ReadBus1, 128'd0);
            check($sformatf("cleared_rd2_%0d", rd_addrs[k]), ReadBus2, 128'd0);
        end

        // Reset in the middle of a sweep; the partial sweep must not resume.
        WriteEnable  = 1'b1;
        WriteAddress = 16'd50;
        WriteBus     = JUNK;
        step();
        WriteAddress = 16'd200;
        step();
        WriteEnable = 1'b0;
        clear_req   = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 100; i++) step();
        check("midclear_busy_before_reset", clear_busy, 128'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", clear_busy, 128'd0);
        check("async_reset_done", clear_done, 128'd0);
        check("async_reset_rd1",  ReadBus1,   128'd0);
        check("async_reset_oob",  oob_err,    128'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        step();
        step();
        check("no_resume_busy", clear_busy, 128'd0);
        ReadAddress1 = 16'd200;
        ReadAddress2 = 16'd50;
        step();
        check("partial_uncleared_200", ReadBus1, JUNK);
        check("partial_cleared_50",    ReadBus2, 128'd0);

        run_clear(1'b0, n_busy);
        check("reclear_busy_cycles", 128'(n_busy), 128'd256);
        check("reclear_done_pulse",  clear_done, 128'd1);
        ReadAddress1 = 16'd200;
        step();
        check("reclear_rd_200", ReadBus1, 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
